gf2_poly_divider: RTL and testbench

- Bit-serial GF(2)[x] long divider. Computes quotient and remainder of a carry-less dividend by a carry-less divisor.
- It is the inverse companion of the three-way Toom-Cook carry-less multiplier. Typical uses: reducing its 448-bit product modulo a field polynomial, or checking a product round-trip.
- One dividend bit per cycle, MSB first. Start/busy/done handshake.

---
 rtl/gf2_poly_divider.sv | 192 +++++++++++++++++++
 tb/tb_gf2_poly_divider.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/gf2_poly_divider.sv
// gf2_poly_divider
//   Bit-serial GF(2)[x] long divider: quotient = floor(A/d), remainder = A mod d,
//   both carry-less. One dividend bit per cycle, MSB first.
//
//   Flow: the divisor is first normalised (shifted left k times until its top
//   bit is set). A*x^k is then divided by d*x^k in DW+k steps. The remainder
//   comes out scaled by x^k and is shifted back right k times.
//
//   Parameters: DW - dividend/quotient width, SW - divisor/remainder width
//               (2 <= SW <= DW).
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     start             request, sampled only in IDLE
//     dividend, divisor operands, captured when start is accepted
//     busy              high in NORM, DIV, FIX
//     done              one-cycle result-valid pulse
//     div_by_zero       divisor was zero (held until next accepted start)
//     quotient          DW-bit quotient (held until next accepted start)
//     remainder         SW-bit remainder (held until next accepted start)
//
//   Build option: GF2DIV_REM_ONLY_EN removes the quotient shift register and
//   ties quotient to 0; remainder path, FSM and latency are unchanged.
module gf2_poly_divider #(
   parameter int DW = 448,
   parameter int SW = 224
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [SW-1:0] divisor,
   output logic          busy,
   output logic          done,
   output logic          div_by_zero,
   output logic [DW-1:0] quotient,
   output logic [SW-1:0] remainder
);

   localparam int KW = $clog2(SW);
   localparam int CW = $clog2(DW + SW);

   typedef enum logic [2:0] {
      S_IDLE,
      S_NORM,
      S_DIV,
      S_FIX,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] a_q, a_d;      // dividend, consumed from the top; zeros shift in as padding
   logic [SW-1:0] dn_q, dn_d;    // normalised divisor d*x^k
   logic [SW-1:0] r_q, r_d;      // partial remainder
   logic [KW-1:0] k_q, k_d;      // normalisation shift count
   logic [CW-1:0] cnt_q, cnt_d;  // step counter for DIV / FIX
   logic          dbz_q, dbz_d;
   logic [SW-1:0] rem_q, rem_d;
   logic          t;             // quotient bit of the current DIV step

`ifndef GF2DIV_REM_ONLY_EN
   logic [DW-1:0] q_q, q_d;
   logic [DW-1:0] quot_q, quot_d;
`endif

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      dn_d    = dn_q;
      r_d     = r_q;
      k_d     = k_q;
      cnt_d   = cnt_q;
      dbz_d   = dbz_q;
      rem_d   = rem_q;
      t       = 1'b0;
`ifndef GF2DIV_REM_ONLY_EN
      q_d     = q_q;
      quot_d  = quot_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = dividend;
               dn_d    = divisor;
               k_d     = '0;
               r_d     = '0;
               dbz_d   = 1'b0;
`ifndef GF2DIV_REM_ONLY_EN
               q_d     = '0;
`endif
               state_d = S_NORM;
            end
         end

         S_NORM: begin
            if (dn_q == '0) begin
               // Zero divisor: one pass through FIX (R is 0, so the shift is
               // harmless) puts done after edge 2 as for any other exit path.
               dbz_d   = 1'b1;
               cnt_d   = '0;
               state_d = S_FIX;
            end else if (!dn_q[SW-1]) begin
               dn_d = dn_q << 1;
               k_d  = k_q + KW'(1);
            end else begin
               cnt_d   = CW'(DW) + CW'(k_q) - CW'(1);
               state_d = S_DIV;
            end
         end

         S_DIV: begin
            // R always holds deg < SW-1; the bit about to move into R[SW-1]
            // decides whether the normalised divisor is subtracted this step.
            t     = r_q[SW-2];
            r_d   = {r_q[SW-2:0], a_q[DW-1]} ^ (t ? dn_q : '0);
            a_d   = a_q << 1;
`ifndef GF2DIV_REM_ONLY_EN
            q_d   = {q_q[DW-2:0], t};
`endif
            if (cnt_q == '0) begin
               if (k_q != '0) begin
                  cnt_d   = CW'(k_q) - CW'(1);
                  state_d = S_FIX;
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

         S_FIX: begin
            r_d = r_q >> 1;
            if (cnt_q == '0) state_d = S_DONE;
            else             cnt_d   = cnt_q - CW'(1);
         end

         S_DONE: state_d = S_IDLE;

         default: state_d = S_IDLE;
      endcase

      // Results become visible on the edge that enters DONE.
      if (state_d == S_DONE && state_q != S_DONE) begin
         rem_d  = dbz_d ? '0 : r_d;
`ifndef GF2DIV_REM_ONLY_EN
         quot_d = dbz_d ? '0 : q_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         dn_q    <= '0;
         r_q     <= '0;
         k_q     <= '0;
         cnt_q   <= '0;
         dbz_q   <= 1'b0;
         rem_q   <= '0;
`ifndef GF2DIV_REM_ONLY_EN
         q_q     <= '0;
         quot_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         dn_q    <= dn_d;
         r_q     <= r_d;
         k_q     <= k_d;
         cnt_q   <= cnt_d;
         dbz_q   <= dbz_d;
         rem_q   <= rem_d;
`ifndef GF2DIV_REM_ONLY_EN
         q_q     <= q_d;
         quot_q  <= quot_d;
`endif
      end
   end

   assign busy        = (state_q == S_NORM) || (state_q == S_DIV) || (state_q == S_FIX);
   assign done        = (state_q == S_DONE);
   assign div_by_zero = dbz_q;
   assign remainder   = rem_q;
`ifndef GF2DIV_REM_ONLY_EN
   assign quotient    = quot_q;
`else
   assign quotient    = '0;
`endif

endmodule

// File: tb/tb_gf2_poly_divider.sv
// Self-checking bench for gf2_poly_divider (DW=448, SW=224).
module tb_gf2_poly_divider;
   localparam int DW = 448;
   localparam int SW = 224;
   localparam int LIMIT = 2000;
`ifdef GF2DIV_REM_ONLY_EN
   localparam bit REM_ONLY = 1'b1;
`else
   localparam bit REM_ONLY = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst, start;
   logic [DW-1:0] dividend;
   logic [SW-1:0] divisor;
   logic          busy, done, div_by_zero;
   logic [DW-1:0] quotient;
   logic [SW-1:0] remainder;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   gf2_poly_divider #(.DW(DW), .SW(SW)) dut (
      .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done), .div_by_zero(div_by_zero),
      .quotient(quotient), .remainder(remainder)
   );

   function automatic logic [DW-1:0] clmul(input logic [SW-1:0] a, input logic [SW-1:0] b);
      logic [DW-1:0] acc = '0;
      for (int i = 0; i < SW; i++)
         if (b[i]) acc ^= (DW'(a) << i);
      return acc;
   endfunction

   function automatic logic [SW-1:0] rnd_sw();
      logic [SW-1:0] v;
      for (int i = 0; i < SW / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Starts one operation and waits for done. lat = edges after the start edge.
   task automatic run_op(input logic [DW-1:0] a, input logic [SW-1:0] d,
                         output int lat, output logic dbz0);
      @(negedge clk);
      dividend = a; divisor = d; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      dbz0 = div_by_zero;
      lat = 0;
      while (done !== 1'b1 && lat < LIMIT) begin
         @(posedge clk); lat++; @(negedge clk);
      end
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL timeout got_done=%b exp_done=1 after %0d edges", done, lat);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0)        begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
      checks++; if (quotient !== '0)      begin failures++; $display("FAIL reset_q got=%h exp=0", quotient); end
      checks++; if (remainder !== '0)     begin failures++; $display("FAIL reset_r got=%h exp=0", remainder); end
      rst = 1'b0;
   endtask

   task automatic test_div_by_zero();
      int lat; logic z;
      run_op(DW'(48'h1234_5678_9ABC), '0, lat, z);
      checks++; if (lat !== 2)            begin failures++; $display("FAIL dbz_lat got=%0d exp=2", lat); end
      checks++; if (div_by_zero !== 1'b1) begin failures++; $display("FAIL dbz_flag got=%b exp=1", div_by_zero); end
      checks++; if (quotient !== '0)      begin failures++; $display("FAIL dbz_q got=%h exp=0", quotient); end
      checks++; if (remainder !== '0)     begin failures++; $display("FAIL dbz_r got=%h exp=0", remainder); end
      checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL dbz_busy got=%b exp=0", busy); end
   endtask

   task automatic test_k0();
      int lat; logic z;
      logic [SW-1:0] d;
      logic [DW-1:0] a, eq;
      d  = (SW'(1) << 223) | SW'(3);
      a  = (DW'(d) << 5) ^ DW'(9);
      eq = REM_ONLY ? '0 : DW'(32'h20);
      run_op(a, d, lat, z);
      checks++; if (z !== 1'b0)           begin failures++; $display("FAIL dbz_clear got=%b exp=0", z); end
      checks++; if (lat !== 449)          begin failures++; $display("FAIL k0_lat got=%0d exp=449", lat); end
      checks++; if (quotient !== eq)      begin failures++; $display("FAIL k0_q got=%h exp=%h", quotient, eq); end
      checks++; if (remainder !== SW'(9)) begin failures++; $display("FAIL k0_r got=%h exp=9", remainder); end
      checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL k0_dbz got=%b exp=0", div_by_zero); end
   endtask

   task automatic test_basic();
      int lat; logic z;
      logic [DW-1:0] eq;
      eq = REM_ONLY ? '0 : DW'(4);
      run_op(DW'(8'h1F), SW'(4'h7), lat, z);
      checks++; if (lat !== 1112)         begin failures++; $display("FAIL basic_lat got=%0d exp=1112", lat); end
      checks++; if (quotient !== eq)      begin failures++; $display("FAIL basic_q got=%h exp=%h", quotient, eq); end
      checks++; if (remainder !== SW'(3)) begin failures++; $display("FAIL basic_r got=%h exp=3", remainder); end
      checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL basic_dbz got=%b exp=0", div_by_zero); end
      @(negedge clk);
      checks++; if (done !== 1'b0)        begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
      checks++; if (remainder !== SW'(3)) begin failures++; $display("FAIL basic_r_hold got=%h exp=3", remainder); end
   endtask

   task automatic test_start_while_busy();
      int ndone = 0;
      int lat = -1;
      logic pulse_next = 1'b0;
      logic [DW-1:0] q = '0, eq;
      logic [SW-1:0] r = '0;
      eq = REM_ONLY ? '0 : DW'(4);
      @(negedge clk);
      dividend = DW'(8'h1F); divisor = SW'(4'h7); start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 1200; c++) begin
         start = (c == 3 || c == 300 || c == 900) || pulse_next;
         pulse_next = 1'b0;
         if (start) begin dividend = DW'(8'hFF); divisor = SW'(2'h3); end
         @(posedge clk);
         @(negedge clk);
         if (done === 1'b1) begin
            ndone++;
            if (ndone == 1) begin lat = c; q = quotient; r = remainder; end
            pulse_next = 1'b1;  // start during DONE must be ignored too
         end
      end
      start = 1'b0;
      checks++; if (ndone !== 1)   begin failures++; $display("FAIL busy_ndone got=%0d exp=1", ndone); end
      checks++; if (lat !== 1112)  begin failures++; $display("FAIL busy_lat got=%0d exp=1112", lat); end
      checks++; if (q !== eq)      begin failures++; $display("FAIL busy_q got=%h exp=%h", q, eq); end
      checks++; if (r !== SW'(3))  begin failures++; $display("FAIL busy_r got=%h exp=3", r); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_not_queued got=%b exp=0", busy); end
   endtask

   task automatic test_reset_mid_div();
      int lat; logic z;
      @(negedge clk);
      dividend = DW'(8'h1F); divisor = SW'(4'h7); start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (500) @(negedge clk);
      checks++; if (busy !== 1'b1)    begin failures++; $display("FAIL mid_busy got=%b exp=1", busy); end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0)    begin failures++; $display("FAIL rstmid_done got=%b exp=0", done); end
      checks++; if (quotient !== '0)  begin failures++; $display("FAIL rstmid_q got=%h exp=0", quotient); end
      checks++; if (remainder !== '0) begin failures++; $display("FAIL rstmid_r got=%h exp=0", remainder); end
      // A below d in degree, run right after the abort.
      run_op(DW'(4'h5), SW'(12'h100), lat, z);
      checks++; if (lat !== 1094)         begin failures++; $display("FAIL lt_lat got=%0d exp=1094", lat); end
      checks++; if (quotient !== '0)      begin failures++; $display("FAIL lt_q got=%h exp=0", quotient); end
      checks++; if (remainder !== SW'(5)) begin failures++; $display("FAIL lt_r got=%h exp=5", remainder); end
   endtask

   task automatic test_round_trip();
      int lat, dg, elat; logic z;
      logic [SW-1:0] a, b;
      logic [DW-1:0] c, eq;
      for (int n = 0; n < 100; n++) begin
         a = rnd_sw();
         b = rnd_sw();
         if (b == '0) b = SW'(1);
         c = clmul(a, b);
         dg = 0;
         for (int i = 0; i < SW; i++) if (b[i]) dg = i;
         elat = DW + 3 * (SW - 1 - dg) + 1;
         eq = REM_ONLY ? '0 : DW'(a);
         run_op(c, b, lat, z);
         checks++; if (lat !== elat)     begin failures++; $display("FAIL rt%0d_lat got=%0d exp=%0d", n, lat, elat); end
         checks++; if (quotient !== eq)  begin failures++; $display("FAIL rt%0d_q got=%h exp=%h", n, quotient, eq); end
         checks++; if (remainder !== '0) begin failures++; $display("FAIL rt%0d_r got=%h exp=0", n, remainder); end
      end
   endtask

   initial begin
      test_reset();
      test_div_by_zero();
      test_k0();
      test_basic();
      test_start_while_busy();
      test_reset_mid_div();
      test_round_trip();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
